// File: rtl/psum_quant.sv
// psum_quant: sums ntile mac results per output pixel, then applies bias, round-half-up shift, ReLU and int8 saturation.
// Build option: define PSUM_QUANT_LEAKY_EN to make ReLU leaky (negative values scaled by 1/8, floor) instead of clamped to zero.
module psum_quant #(
    parameter int ACC_W  = 20,
    parameter int PSUM_W = 32,
    parameter int OUT_W  = 8,
    parameter int TILE_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic              vld_i,
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [TILE_W-1:0] cfg_ntile,
    input  logic [4:0]        cfg_shift,
    input  logic              cfg_relu,
    input  logic [PSUM_W-1:0] bias_i,
    output logic              vld_o,
    output logic [OUT_W-1:0]  dout,
    output logic              busy_o,
    output logic [15:0]       out_cnt
);
    // Handshake: vld_i qualifies acc_i for exactly one cycle and is always consumed (there is
    // no ready); vld_o is a one-cycle pulse qualifying dout, also without any ready.

    // Two guard bits keep psum+bias+rounding free of wrap before saturation.
    localparam int EXT_W = PSUM_W + 2;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    // Accumulation stage state and config latched at group start
    logic [TILE_W-1:0] cnt_q, cnt_d;
    logic [PSUM_W-1:0] psum_q, psum_d;
    logic [TILE_W-1:0] ntile_q, ntile_d;
    logic [4:0]        shift_q, shift_d;
    logic              relu_q, relu_d;
    logic [PSUM_W-1:0] bias_q, bias_d;

    // Stage 1: completed group sum plus its config
    logic              s1_vld_q, s1_vld_d;
    logic [PSUM_W-1:0] s1_psum_q, s1_psum_d;
    logic [PSUM_W-1:0] s1_bias_q, s1_bias_d;
    logic [4:0]        s1_shift_q, s1_shift_d;
    logic              s1_relu_q, s1_relu_d;

    // Stage 2: biased, rounded and shifted value
    logic                    s2_vld_q, s2_vld_d;
    logic signed [EXT_W-1:0] s2_t_q, s2_t_d;
    logic                    s2_relu_q, s2_relu_d;

    // Output stage
    logic              vld_q, vld_d;
    logic [OUT_W-1:0]  dout_q, dout_d;
    logic [15:0]       out_cnt_q, out_cnt_d;

    logic              grp_start;
    logic              grp_last;
    logic [TILE_W-1:0] ntile_sel;
    logic [TILE_W-1:0] ntile_last;
    logic [PSUM_W-1:0] acc_ext;
    logic [PSUM_W-1:0] psum_sum;

    logic signed [EXT_W-1:0] t_sum;
    logic signed [EXT_W-1:0] t_rnd;
    logic signed [EXT_W-1:0] t_pre;
    logic signed [EXT_W-1:0] t_act;
    logic [OUT_W-1:0]        q_sat;

    // The first input of a group uses the live config, later ones the latched copy.
    always_comb begin
        grp_start  = (cnt_q == '0);
        ntile_sel  = grp_start ? cfg_ntile : ntile_q;
        ntile_last = (ntile_sel == '0) ? '0 : ntile_sel - TILE_W'(1);
        grp_last   = (cnt_q == ntile_last);
        acc_ext    = {{(PSUM_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
        psum_sum   = grp_start ? acc_ext : psum_q + acc_ext;
    end

    always_comb begin
        cnt_d      = cnt_q;
        psum_d     = psum_q;
        ntile_d    = ntile_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        bias_d     = bias_q;
        s1_vld_d   = 1'b0;
        s1_psum_d  = s1_psum_q;
        s1_bias_d  = s1_bias_q;
        s1_shift_d = s1_shift_q;
        s1_relu_d  = s1_relu_q;
        if (clr_i) begin
            cnt_d  = '0;
            psum_d = '0;
        end else if (vld_i) begin
            psum_d = psum_sum;
            if (grp_start) begin
                ntile_d = cfg_ntile;
                shift_d = cfg_shift;
                relu_d  = cfg_relu;
                bias_d  = bias_i;
            end
            if (grp_last) begin
                cnt_d      = '0;
                s1_vld_d   = 1'b1;
                s1_psum_d  = psum_sum;
                s1_bias_d  = grp_start ? bias_i : bias_q;
                s1_shift_d = grp_start ? cfg_shift : shift_q;
                s1_relu_d  = grp_start ? cfg_relu : relu_q;
            end else begin
                cnt_d = cnt_q + TILE_W'(1);
            end
        end
    end

    always_comb begin
        t_sum = {{2{s1_psum_q[PSUM_W-1]}}, s1_psum_q} + {{2{s1_bias_q[PSUM_W-1]}}, s1_bias_q};
        t_rnd = '0;
        if (s1_shift_q != 5'd0) begin
            t_rnd = EXT_W'(1) << (s1_shift_q - 5'd1);
        end
        t_pre     = t_sum + t_rnd;
        s2_vld_d  = s1_vld_q && !clr_i;
        s2_t_d    = s1_vld_q ? (t_pre >>> s1_shift_q) : s2_t_q;
        s2_relu_d = s1_vld_q ? s1_relu_q : s2_relu_q;
    end

    always_comb begin
        t_act = s2_t_q;
        if (s2_relu_q && s2_t_q[EXT_W-1]) begin
`ifdef PSUM_QUANT_LEAKY_EN
            t_act = s2_t_q >>> 3;
`else
            t_act = '0;
`endif
        end
        if (t_act > SAT_MAX) begin
            q_sat = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (t_act < SAT_MIN) begin
            q_sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            q_sat = t_act[OUT_W-1:0];
        end
    end

    // dout keeps its last value across clr_i; only the valid and the count are cleared.
    always_comb begin
        vld_d     = s2_vld_q && !clr_i;
        dout_d    = vld_d ? q_sat : dout_q;
        out_cnt_d = out_cnt_q;
        if (clr_i) begin
            out_cnt_d = '0;
        end else if (vld_d) begin
            out_cnt_d = out_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            psum_q     <= '0;
            ntile_q    <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            bias_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_psum_q  <= '0;
            s1_bias_q  <= '0;
            s1_shift_q <= '0;
            s1_relu_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_t_q     <= '0;
            s2_relu_q  <= 1'b0;
            vld_q      <= 1'b0;
            dout_q     <= '0;
            out_cnt_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            psum_q     <= psum_d;
            ntile_q    <= ntile_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            bias_q     <= bias_d;
            s1_vld_q   <= s1_vld_d;
            s1_psum_q  <= s1_psum_d;
            s1_bias_q  <= s1_bias_d;
            s1_shift_q <= s1_shift_d;
            s1_relu_q  <= s1_relu_d;
            s2_vld_q   <= s2_vld_d;
            s2_t_q     <= s2_t_d;
            s2_relu_q  <= s2_relu_d;
            vld_q      <= vld_d;
            dout_q     <= dout_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign vld_o   = vld_q;
    assign dout    = dout_q;
    assign out_cnt = out_cnt_q;
    assign busy_o  = (cnt_q != '0) | s1_vld_q | s2_vld_q | vld_q;

endmodule
